// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared types, key indices, field limits and helpers for the timekeeping core
package clock_pkg;

    typedef logic [7:0] bcd8_t;

    localparam int KEY_SS_DEC = 0;
    localparam int KEY_SS_INC = 1;
    localparam int KEY_MM_DEC = 2;
    localparam int KEY_MM_INC = 3;
    localparam int KEY_HH_DEC = 4;
    localparam int KEY_HH_INC = 5;

    localparam int HH_MAX = 23;
    localparam int MS_MAX = 59;

    typedef enum logic {
        RUN = 1'b0,
        SET = 1'b1
    } clk_state_e;

    // Higher key index wins, so the last hit in the ascending scan is kept.
    function automatic logic [5:0] prio_onehot(input logic [5:0] req);
        logic [5:0] sel;
        sel = '0;
        for (int i = 0; i < 6; i++) begin
            if (req[i]) begin
                sel = 6'b000001 << i;
            end
        end
        return sel;
    endfunction

    function automatic int ms_to_cycles(input longint f_clk, input longint ms);
        longint c;
        c = (f_clk * ms) / 1000;
        return (c < 1) ? 1 : int'(c);
    endfunction

endpackage

// File: rtl/bcd_field_counter.sv
// rtl/bcd_field_counter.sv - modulo-(MAX+1) counter kept as two BCD digits
module bcd_field_counter
    import clock_pkg::*;
#(
    parameter int MAX = 59
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc,
    input  logic       dec,
    input  logic       wrap_en_carry,
    output logic [7:0] bcd,
    output logic       carry_out
);

    localparam logic [3:0] MAX_T = 4'(MAX / 10);
    localparam logic [3:0] MAX_U = 4'(MAX % 10);

    logic [3:0] tens_q, tens_d;
    logic [3:0] units_q, units_d;
    logic       at_max;
    logic       at_zero;
    bcd8_t      bcd_w;

    assign at_max  = (tens_q == MAX_T) && (units_q == MAX_U);
    assign at_zero = (tens_q == 4'd0) && (units_q == 4'd0);

    always_comb begin
        tens_d  = tens_q;
        units_d = units_q;
        if (inc) begin
            if (at_max) begin
                tens_d  = 4'd0;
                units_d = 4'd0;
            end else if (units_q == 4'd9) begin
                tens_d  = tens_q + 4'd1;
                units_d = 4'd0;
            end else begin
                units_d = units_q + 4'd1;
            end
        end else if (dec) begin
            if (at_zero) begin
                tens_d  = MAX_T;
                units_d = MAX_U;
            end else if (units_q == 4'd0) begin
                tens_d  = tens_q - 4'd1;
                units_d = 4'd9;
            end else begin
                units_d = units_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tens_q  <= 4'd0;
            units_q <= 4'd0;
        end else begin
            tens_q  <= tens_d;
            units_q <= units_d;
        end
    end

    // Carry is combinational so the whole HH:MM:SS chain settles on one edge.
    assign carry_out = inc & at_max & wrap_en_carry;
    assign bcd_w     = {tens_q, units_q};
    assign bcd       = bcd_w;

endmodule

// File: rtl/clock_time_keeper.sv
// rtl/clock_time_keeper.sv - 24h HH:MM:SS core with RUN/SET FSM; CLOCK_KEY_REPEAT_EN adds hold auto-repeat
module clock_time_keeper
    import clock_pkg::*;
#(
    parameter int F_CLK           = 50000000,
    parameter int SET_TIMEOUT_S   = 5,
    parameter int REPEAT_DELAY_MS = 500,
    parameter int REPEAT_RATE_MS  = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] key_state,
    output logic [7:0] hh_bcd,
    output logic [7:0] mm_bcd,
    output logic [7:0] ss_bcd,
    output logic       set_mode,
    output logic       tick_1hz
);

    localparam int            PW         = $clog2(F_CLK);
    localparam logic [PW-1:0] PRESC_LAST = PW'(F_CLK - 1);
    localparam logic [3:0]    TO_LAST    = 4'(SET_TIMEOUT_S - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    to_q, to_d;
    clk_state_e    state_q, state_d;
    logic [5:0]    key_hist_q, key_hist_d;
    logic          armed_q, armed_d;

    logic       tick;
    logic [5:0] edge_vec;
    logic [5:0] press_vec;
    logic [5:0] sel;
    logic       press_any;
    logic       run_tick;
    logic       ss_carry, mm_carry, unused_hh_carry;

    assign tick = (presc_q == PRESC_LAST);

    // armed_q masks the first cycle after reset so a key held through reset is not a press.
    assign edge_vec = armed_q ? (key_hist_q & ~key_state) : 6'b000000;

`ifdef CLOCK_KEY_REPEAT_EN
    localparam int DLY_CYC = ms_to_cycles(longint'(F_CLK), longint'(REPEAT_DELAY_MS));
    localparam int RPT_CYC = ms_to_cycles(longint'(F_CLK), longint'(REPEAT_RATE_MS));
    localparam int HW      = $clog2(((DLY_CYC > RPT_CYC) ? DLY_CYC : RPT_CYC) + 1);
    localparam logic [HW-1:0] DLY_LIM = HW'(DLY_CYC);
    localparam logic [HW-1:0] RPT_LIM = HW'(RPT_CYC);

    logic [5:0][HW-1:0] hold_q, hold_d;
    logic [5:0]         rep_q, rep_d;
    logic [5:0]         syn_vec;

    // hold counts cycles since the qualifying edge; zero means idle or untracked.
    always_comb begin
        hold_d  = hold_q;
        rep_d   = rep_q;
        syn_vec = '0;
        for (int i = 0; i < 6; i++) begin
            if (key_state[i]) begin
                hold_d[i] = '0;
                rep_d[i]  = 1'b0;
            end else if (edge_vec[i]) begin
                hold_d[i] = HW'(1);
                rep_d[i]  = 1'b0;
            end else if (hold_q[i] != '0) begin
                if (hold_q[i] == (rep_q[i] ? RPT_LIM : DLY_LIM)) begin
                    syn_vec[i] = 1'b1;
                    hold_d[i]  = HW'(1);
                    rep_d[i]   = 1'b1;
                end else begin
                    hold_d[i] = hold_q[i] + HW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
            rep_q  <= '0;
        end else begin
            hold_q <= hold_d;
            rep_q  <= rep_d;
        end
    end

    assign press_vec = edge_vec | syn_vec;
`else
    localparam int UNUSED_REPEAT_CFG = REPEAT_DELAY_MS + REPEAT_RATE_MS;

    assign press_vec = edge_vec;
`endif

    assign sel       = prio_onehot(press_vec);
    assign press_any = |press_vec;
    assign run_tick  = tick & ~press_any & (state_q == RUN);

    bcd_field_counter #(.MAX(MS_MAX)) u_ss (
        .clk           (clk),
        .rst_n         (rst_n),
        .inc           (sel[KEY_SS_INC] | run_tick),
        .dec           (sel[KEY_SS_DEC]),
        .wrap_en_carry (run_tick),
        .bcd           (ss_bcd),
        .carry_out     (ss_carry)
    );

    bcd_field_counter #(.MAX(MS_MAX)) u_mm (
        .clk           (clk),
        .rst_n         (rst_n),
        .inc           (sel[KEY_MM_INC] | ss_carry),
        .dec           (sel[KEY_MM_DEC]),
        .wrap_en_carry (run_tick),
        .bcd           (mm_bcd),
        .carry_out     (mm_carry)
    );

    bcd_field_counter #(.MAX(HH_MAX)) u_hh (
        .clk           (clk),
        .rst_n         (rst_n),
        .inc           (sel[KEY_HH_INC] | mm_carry),
        .dec           (sel[KEY_HH_DEC]),
        .wrap_en_carry (run_tick),
        .bcd           (hh_bcd),
        .carry_out     (unused_hh_carry)
    );

    always_comb begin
        presc_d    = tick ? '0 : presc_q + PW'(1);
        to_d       = to_q;
        state_d    = state_q;
        key_hist_d = key_state;
        armed_d    = 1'b1;
        if (press_any) begin
            state_d = SET;
            to_d    = 4'd0;
        end else if (tick && (state_q == SET)) begin
            if (to_q == TO_LAST) begin
                state_d = RUN;
                to_d    = 4'd0;
                presc_d = '0;
            end else begin
                to_d = to_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q    <= '0;
            to_q       <= 4'd0;
            state_q    <= RUN;
            key_hist_q <= 6'b111111;
            armed_q    <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            to_q       <= to_d;
            state_q    <= state_d;
            key_hist_q <= key_hist_d;
            armed_q    <= armed_d;
        end
    end

    assign set_mode = (state_q == SET);
    assign tick_1hz = tick;

endmodule

// File: tb/tb_clock_time_keeper.sv
// tb/tb_clock_time_keeper.sv - self-checking bench: vector table, corner sequences, random run vs time-of-day model
module tb_clock_time_keeper;

    localparam int F_CLK    = 10;
    localparam int TO_S     = 3;
    localparam int RDLY_MS  = 500;
    localparam int RRATE_MS = 100;
    localparam int D_CYC    = F_CLK * RDLY_MS / 1000;
    localparam int R_CYC    = F_CLK * RRATE_MS / 1000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] key_state;
    logic [7:0] hh_bcd, mm_bcd, ss_bcd;
    logic       set_mode, tick_1hz;

    int n_pass = 0;
    int n_total = 0;
    int n_rand_fail = 0;

    always #5 clk = ~clk;

    clock_time_keeper #(
        .F_CLK           (F_CLK),
        .SET_TIMEOUT_S   (TO_S),
        .REPEAT_DELAY_MS (RDLY_MS),
        .REPEAT_RATE_MS  (RRATE_MS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_state (key_state),
        .hh_bcd    (hh_bcd),
        .mm_bcd    (mm_bcd),
        .ss_bcd    (ss_bcd),
        .set_mode  (set_mode),
        .tick_1hz  (tick_1hz)
    );

    // Reference model: time of day as seconds since midnight.
    int         m_t = 0;
    int         m_to = 0;
    int         m_pre = 0;
    bit         m_set = 0;
    bit         m_armed = 0;
    logic [5:0] m_prev = 6'h3f;
    int         m_hold[6];
    bit         m_track[6];

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic model_step();
        logic [5:0] pr;
        int sel, h, m, s;
        bit tk;
        tk = (m_pre == F_CLK - 1);
        pr = m_armed ? (m_prev & ~key_state) : 6'b0;
`ifdef CLOCK_KEY_REPEAT_EN
        for (int i = 0; i < 6; i++) begin
            if (key_state[i]) begin
                m_track[i] = 0;
            end else if (pr[i]) begin
                m_track[i] = 1;
                m_hold[i]  = 0;
            end else if (m_track[i]) begin
                m_hold[i]++;
                if (m_hold[i] >= D_CYC && ((m_hold[i] - D_CYC) % R_CYC) == 0) pr[i] = 1'b1;
            end
        end
`endif
        sel = -1;
        for (int i = 0; i < 6; i++) if (pr[i]) sel = i;
        m_pre = tk ? 0 : m_pre + 1;
        if (sel >= 0) begin
            h = m_t / 3600;
            m = (m_t / 60) % 60;
            s = m_t % 60;
            case (sel)
                5: h = (h + 1) % 24;
                4: h = (h + 23) % 24;
                3: m = (m + 1) % 60;
                2: m = (m + 59) % 60;
                1: s = (s + 1) % 60;
                default: s = (s + 59) % 60;
            endcase
            m_t   = h * 3600 + m * 60 + s;
            m_set = 1;
            m_to  = 0;
        end else if (tk) begin
            if (!m_set) begin
                m_t = (m_t + 1) % 86400;
            end else begin
                m_to++;
                if (m_to == TO_S) begin
                    m_set = 0;
                    m_to  = 0;
                    m_pre = 0;
                end
            end
        end
        m_prev  = key_state;
        m_armed = 1;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_t = 0; m_to = 0; m_pre = 0; m_set = 0; m_armed = 0; m_prev = 6'h3f;
            for (int i = 0; i < 6; i++) begin
                m_hold[i]  = 0;
                m_track[i] = 0;
            end
        end else begin
            model_step();
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Assumes we are at a negedge; returns at a negedge with keys released.
    task automatic press(input logic [5:0] pat);
        key_state = pat;
        @(negedge clk);
        key_state = 6'h3f;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        key_state = 6'h3f;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    typedef struct {
        logic [5:0] keys;
        logic [7:0] hh;
        logic [7:0] mm;
        logic [7:0] ss;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int tk, guard, n;
        logic last_tick;
        logic [7:0] exp_mm;

        tbl[0]  = '{6'b111110, 8'h00, 8'h00, 8'h59};
        tbl[1]  = '{6'b111101, 8'h00, 8'h00, 8'h00};
        tbl[2]  = '{6'b101111, 8'h23, 8'h00, 8'h00};
        tbl[3]  = '{6'b011111, 8'h00, 8'h00, 8'h00};
        tbl[4]  = '{6'b111011, 8'h00, 8'h59, 8'h00};
        tbl[5]  = '{6'b110111, 8'h00, 8'h00, 8'h00};
        tbl[6]  = '{6'b011110, 8'h01, 8'h00, 8'h00};
        tbl[7]  = '{6'b000000, 8'h02, 8'h00, 8'h00};
        tbl[8]  = '{6'b110011, 8'h02, 8'h01, 8'h00};
        tbl[9]  = '{6'b111100, 8'h02, 8'h01, 8'h01};
        tbl[10] = '{6'b101110, 8'h01, 8'h01, 8'h01};
        tbl[11] = '{6'b111010, 8'h01, 8'h00, 8'h01};

        // Key held through reset, then released: no press registers.
        rst_n = 1'b0;
        key_state = 6'b111110;
        repeat (3) @(negedge clk);
        chk("reset_state", {hh_bcd, mm_bcd, ss_bcd, set_mode, tick_1hz}, 26'h0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        key_state = 6'h3f;
        @(negedge clk);
        chk("held_through_reset", {hh_bcd, mm_bcd, ss_bcd, set_mode}, 25'h0);

        for (int i = 0; i < 12; i++) begin
            key_state = tbl[i].keys;
            @(negedge clk);
            chk($sformatf("vec%0d", i), {hh_bcd, mm_bcd, ss_bcd, set_mode},
                {tbl[i].hh, tbl[i].mm, tbl[i].ss, 1'b1});
            key_state = 6'h3f;
            @(negedge clk);
        end

        // Climb to 12:30:15, then hour-inc and second-dec together.
        repeat (11) press(6'b011111);
        repeat (30) press(6'b110111);
        repeat (14) press(6'b111101);
        chk("at_12_30_15", {hh_bcd, mm_bcd, ss_bcd}, 24'h123015);
        key_state = 6'b011110;
        @(negedge clk);
        chk("prio_hh_over_ss", {hh_bcd, mm_bcd, ss_bcd, set_mode}, {24'h133015, 1'b1});
        key_state = 6'h3f;
        @(negedge clk);

        // 23:59:59 via decrements, timeout exit, then midnight wrap on a tick.
        do_reset();
        press(6'b101111);
        press(6'b111011);
        press(6'b111110);
        chk("at_23_59_59", {hh_bcd, mm_bcd, ss_bcd, set_mode}, {24'h235959, 1'b1});
        tk = 0;
        guard = 0;
        while (tk < 3 && guard < 10 * F_CLK) begin
            last_tick = tick_1hz;
            @(negedge clk);
            guard++;
            if (last_tick) begin
                tk++;
                chk($sformatf("set_after_tick%0d", tk), set_mode, (tk < 3));
            end
        end
        chk("timeout_ticks", tk, 3);
        chk("frozen_in_set", {hh_bcd, mm_bcd, ss_bcd}, 24'h235959);
        n = 0;
        last_tick = 1'b0;
        while (ss_bcd == 8'h59 && n < 4 * F_CLK) begin
            last_tick = tick_1hz;
            @(negedge clk);
            n++;
        end
        chk("exit_to_inc_cycles", n, F_CLK);
        chk("wrap_on_tick", last_tick, 1'b1);
        chk("midnight", {hh_bcd, mm_bcd, ss_bcd, set_mode}, {24'h000000, 1'b0});

        // Press coincident with a RUN tick: adjustment wins, increment dropped.
        guard = 0;
        while (!tick_1hz && guard < 2 * F_CLK) begin
            @(negedge clk);
            guard++;
        end
        chk("tick_found", tick_1hz, 1'b1);
        key_state = 6'b110111;
        @(negedge clk);
        chk("press_beats_tick", {hh_bcd, mm_bcd, ss_bcd, set_mode}, {24'h000100, 1'b1});
        key_state = 6'h3f;
        @(negedge clk);

        // Minute-inc held for delay + 3 repeat periods.
        key_state = 6'b110111;
        repeat (D_CYC + 3 * R_CYC) @(negedge clk);
        key_state = 6'h3f;
        @(negedge clk);
`ifdef CLOCK_KEY_REPEAT_EN
        exp_mm = 8'h05;
`else
        exp_mm = 8'h02;
`endif
        chk("hold_mm", {hh_bcd, mm_bcd, ss_bcd}, {8'h00, exp_mm, 8'h00});

        // Random bursts and quiet stretches against the model.
        for (int it = 0; it < 40 && n_rand_fail < 10; it++) begin
            int quiet;
            if (it == 20) begin
                #2 rst_n = 1'b0;
                #1 chk("async_reset", {hh_bcd, mm_bcd, ss_bcd, set_mode, tick_1hz}, 26'h0);
                @(negedge clk);
                rst_n = 1'b1;
            end
            for (int c = 0; c < 30; c++) begin
                for (int b = 0; b < 6; b++) begin
                    if (!key_state[b]) begin
                        if ($urandom_range(0, 3) == 0) key_state[b] = 1'b1;
                    end else if ($urandom_range(0, 15) == 0) begin
                        key_state[b] = 1'b0;
                    end
                end
                @(negedge clk);
                chk("rand_model", {hh_bcd, mm_bcd, ss_bcd, set_mode, tick_1hz},
                    {to_bcd(m_t / 3600), to_bcd((m_t / 60) % 60), to_bcd(m_t % 60),
                     m_set, (m_pre == F_CLK - 1)});
                if (n_pass != n_total) n_rand_fail++;
            end
            key_state = 6'h3f;
            quiet = $urandom_range(0, 60);
            for (int c = 0; c < quiet; c++) begin
                @(negedge clk);
                chk("quiet_model", {hh_bcd, mm_bcd, ss_bcd, set_mode, tick_1hz},
                    {to_bcd(m_t / 3600), to_bcd((m_t / 60) % 60), to_bcd(m_t % 60),
                     m_set, (m_pre == F_CLK - 1)});
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
